fu_cdb_arbiter: RTL and testbench
=================================

FU_CDB_ARBITER -- requirements
Module: fu_cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit result ports.
REQ-002 Parameter DEPTH, default 2: per-port result-buffer entries; power of two, 2 or more.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous pipeline flush; discards all buffered results.
REQ-006 fu_valid  input  NUM_FU  per-port result valid.
REQ-007 fu_ready  output  NUM_FU  per-port buffer can accept a result.
REQ-008 fu_rob_idx  input  NUM_FU x ROB_IDX_W  ROB tag per port.
REQ-009 fu_pd  input  NUM_FU x PREG_W  destination physical register per port.
REQ-010 fu_data  input  NUM_FU x 32  result value per port.
REQ-011 cdb_valid  output  1  broadcast valid.
REQ-012 cdb_rob_idx  output  ROB_IDX_W  broadcast ROB tag.
REQ-013 cdb_pd  output  PREG_W  broadcast physical register.
REQ-014 cdb_data  output  32  broadcast value.

Function
REQ-015 Each port SHALL accept a result (fu_valid & fu_ready) into its own in-order FIFO of DEPTH entries.
REQ-016 fu_ready[i] SHALL be high iff FIFO i holds fewer than DEPTH entries; it does not account for a same-cycle pop.
REQ-017 Exactly zero or one result SHALL be broadcast per cycle; the CDB has no backpressure.
REQ-018 Grant SHALL go round-robin among non-empty FIFOs, searching from the port after the last granted port.
REQ-019 The pointer SHALL advance to the granted port only on a grant; it holds when all FIFOs are empty.
REQ-020 A result pushed in cycle t SHALL NOT be broadcast before cycle t+1; there is no input-to-CDB bypass.
REQ-021 With all FIFOs empty, cdb_valid SHALL be 0; cdb_rob_idx, cdb_pd and cdb_data SHALL be 0.
REQ-022 A push and a pop on the same FIFO in one cycle SHALL both occur; the count is unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; a full/empty ambiguity SHALL be impossible.
REQ-024 flush SHALL empty every FIFO and drop same-cycle pushes.
REQ-025 During the flush cycle, cdb_valid SHALL be 0 and the round-robin pointer SHALL be unchanged.
REQ-026 Results from one port SHALL be broadcast in arrival order; ordering across ports is unspecified beyond REQ-018.

Reset
REQ-027 While rst_n is low, all FIFOs SHALL be empty, the round-robin pointer SHALL be NUM_FU-1 (port 0 searched first) and all CDB outputs SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered results immediately, independent of clk.
REQ-029 After release, fu_ready SHALL be all ones.

Configuration
REQ-030 Macro FU_CDB_ARBITER_OUTREG_EN: when defined, the CDB outputs SHALL come from a register stage.
REQ-031 With the macro, minimum push-to-broadcast latency SHALL be 2 cycles, and flush SHALL also clear the output register.
REQ-032 Without the macro, the CDB outputs SHALL be driven combinationally from the granted FIFO head, with 1-cycle minimum latency.

Structure
REQ-033 ROB_IDX_W (5), PREG_W (6) and the cdb_pkt_t struct (valid, rob_idx, pd, data) SHALL live in rv32i_types.
REQ-034 One sub-module, fu_result_fifo (a single-port in-order buffer with count, push and pop), SHALL be instantiated NUM_FU times.
REQ-035 The round-robin grant logic SHALL be inline in fu_cdb_arbiter.

Verification
REQ-036 Single push: port 2 pushes rob 3, pd 9, data 0xDEADBEEF at t0 -> the CDB shows it at t1 (t2 with macro), then cdb_valid is 0.
REQ-037 Fairness: all 4 ports push every cycle from reset -> grants go 0,1,2,3,0,... and no port waits more than 4 cycles.
REQ-038 Full/backpressure: port 0 pushes 3 results while ports 1-3 stream -> fu_ready[0] drops after 2 entries and 3 broadcasts occur in order.
REQ-039 Flush: all FIFOs full, flush for 1 cycle with concurrent pushes -> the next cycle has cdb_valid 0 and fu_ready all 1, and no stale tag ever appears.
REQ-040 Async reset: rst_n pulses low mid-stream between clock edges -> outputs go to 0 immediately and the first post-reset grant goes to port 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared widths and packet types for the rv32i back end: ROB tags,
// physical-register numbers and the common-data-bus packet.
package rv32i_types;

    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;
    localparam int XLEN      = 32;

    // One buffered functional-unit result; validity is implied by FIFO occupancy.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [XLEN-1:0]      data;
    } fu_result_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [XLEN-1:0]      data;
    } cdb_pkt_t;

    // An idle bus carries all-zero fields, not just a low valid bit.
    function automatic cdb_pkt_t to_cdb(input logic valid, input fu_result_t res);
        cdb_pkt_t pkt;
        pkt = '0;
        if (valid) begin
            pkt.valid   = 1'b1;
            pkt.rob_idx = res.rob_idx;
            pkt.pd      = res.pd;
            pkt.data    = res.data;
        end
        return pkt;
    endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// Single-port in-order result buffer of DEPTH entries (power of two) with an
// occupancy count; flush empties it and drops a same-cycle push.
module fu_result_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  fu_result_t                     wdata,
    output fu_result_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fu_result_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so the increment wraps by itself;
            // the separate count removes any full/empty ambiguity.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty count makes stale
    // contents unobservable and keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// Merges NUM_FU functional-unit result ports onto one common data bus with a
// round-robin grant. Define FU_CDB_ARBITER_OUTREG_EN to register the CDB outputs.
module fu_cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [NUM_FU-1:0]                    fu_valid,
    output logic [NUM_FU-1:0]                    fu_ready,
    input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_idx,
    input  logic [NUM_FU-1:0][PREG_W-1:0]        fu_pd,
    input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
    output logic                                 cdb_valid,
    output logic [ROB_IDX_W-1:0]                 cdb_rob_idx,
    output logic [PREG_W-1:0]                    cdb_pd,
    output logic [XLEN-1:0]                      cdb_data
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fu_result_t        fifo_head  [NUM_FU];
    logic [CNT_W-1:0]  fifo_count [NUM_FU];
    logic [NUM_FU-1:0] fifo_empty;
    logic [NUM_FU-1:0] fifo_pop;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_valid;
    cdb_pkt_t          grant_pkt;
    cdb_pkt_t          cdb_out;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        fu_result_t wdata;
        assign wdata = '{rob_idx: fu_rob_idx[i], pd: fu_pd[i], data: fu_data[i]};

        fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (fu_valid[i]),
            .pop   (fifo_pop[i]),
            .wdata (wdata),
            .rdata (fifo_head[i]),
            .count (fifo_count[i]),
            .empty (fifo_empty[i])
        );

        // Occupancy only; a same-cycle pop does not reopen the port.
        assign fu_ready[i] = (fifo_count[i] < CNT_W'(DEPTH));
    end

    // Search starts at the port after the last grant, so the last winner is
    // considered only after every other port.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_FU; i++) begin
            cand     = (int'(rr_ptr_q) + i) % NUM_FU;
            cand_idx = PTR_W'(cand);
            if (!grant_valid && !fifo_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        fifo_pop  = '0;
        rr_ptr_d  = rr_ptr_q;
        grant_pkt = to_cdb(grant_valid && !flush, fifo_head[grant_idx]);
        if (grant_valid && !flush) begin
            fifo_pop[grant_idx] = 1'b1;
            rr_ptr_d            = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= PTR_W'(NUM_FU - 1);
        else        rr_ptr_q <= rr_ptr_d;
    end

`ifdef FU_CDB_ARBITER_OUTREG_EN
    cdb_pkt_t cdb_q, cdb_d;

    // grant_pkt is already zero during flush, which clears the stage.
    assign cdb_d = grant_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cdb_q <= '0;
        else        cdb_q <= cdb_d;
    end

    // A result staged before a flush is discarded along with the buffers.
    assign cdb_out = flush ? '0 : cdb_q;
`else
    assign cdb_out = grant_pkt;
`endif

    assign cdb_valid   = cdb_out.valid;
    assign cdb_rob_idx = cdb_out.rob_idx;
    assign cdb_pd      = cdb_out.pd;
    assign cdb_data    = cdb_out.data;

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Scoreboard bench for fu_cdb_arbiter: directed stimulus pushes hand-ordered
// expected broadcasts (with their cycle), a negedge monitor pops and compares.
module tb_fu_cdb_arbiter;
    import rv32i_types::*;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
`ifdef FU_CDB_ARBITER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                             clk;
    logic                             rst_n = 1'b0;
    logic                             flush;
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0]                fu_ready;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_FU-1:0][PREG_W-1:0]    fu_pd;
    logic [NUM_FU-1:0][XLEN-1:0]      fu_data;
    logic                             cdb_valid;
    logic [ROB_IDX_W-1:0]             cdb_rob_idx;
    logic [PREG_W-1:0]                cdb_pd;
    logic [XLEN-1:0]                  cdb_data;

    fu_cdb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_rob_idx  (fu_rob_idx),
        .fu_pd       (fu_pd),
        .fu_data     (fu_data),
        .cdb_valid   (cdb_valid),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_pd      (cdb_pd),
        .cdb_data    (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ROB_IDX_W-1:0] rob;
        logic [PREG_W-1:0]    pd;
        logic [XLEN-1:0]      data;
        int                   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   t, u;
    int   cfg_n     [NUM_FU];
    int   cfg_start [NUM_FU];

    function automatic logic [ROB_IDX_W-1:0] mk_rob(input int p, input int s);
        return ROB_IDX_W'((p * 8 + s) % 32);
    endfunction
    function automatic logic [PREG_W-1:0] mk_pd(input int id, input int p, input int s);
        return PREG_W'((id * 13 + p * 4 + s) % 64);
    endfunction
    function automatic logic [XLEN-1:0] mk_data(input int id, input int p, input int s);
        return {8'hA5, 8'(id), 8'(p), 8'(s)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int id, input int p, input int s, input int c);
        exp_t e;
        e.rob  = mk_rob(p, s);
        e.pd   = mk_pd(id, p, s);
        e.data = mk_data(id, p, s);
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic drive_port(input int p, input bit v, input int id, input int s);
        fu_valid[p]   = v;
        fu_rob_idx[p] = v ? mk_rob(p, s) : '0;
        fu_pd[p]      = v ? mk_pd(id, p, s) : '0;
        fu_data[p]    = v ? mk_data(id, p, s) : '0;
    endtask

    task automatic idle_inputs();
        fu_valid   = '0;
        fu_rob_idx = '0;
        fu_pd      = '0;
        fu_data    = '0;
    endtask

    // Valid/ready producer per port: cfg_n results each, starting at cfg_start.
    task automatic run_stream(input int id, input int ncyc);
        int                sent [NUM_FU];
        logic [NUM_FU-1:0] rdy;
        for (int p = 0; p < NUM_FU; p++) sent[p] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < NUM_FU; p++) begin
                if (c >= cfg_start[p] && sent[p] < cfg_n[p]) drive_port(p, 1'b1, id, sent[p]);
                else                                         drive_port(p, 1'b0, 0, 0);
            end
            @(negedge clk);
            rdy = fu_ready;
            @(posedge clk);
            for (int p = 0; p < NUM_FU; p++)
                if (fu_valid[p] && rdy[p]) sent[p]++;
            #1;
        end
        idle_inputs();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        flush = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_cdb_valid", cdb_valid, 0);
        check("reset_cdb_fields", {cdb_rob_idx, cdb_pd, cdb_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", fu_ready, 4'hF);
    endtask

    // Monitor: every broadcast must match the next expected packet and cycle.
    always @(negedge clk) begin
        if (cdb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got rob=%0d pd=%0d data=%h at cycle %0d, required no broadcast",
                         cdb_rob_idx, cdb_pd, cdb_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cdb_rob_idx !== e.rob || cdb_pd !== e.pd || cdb_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL cdb_pkt: got rob=%0d pd=%0d data=%h cycle=%0d, required rob=%0d pd=%0d data=%h cycle=%0d",
                             cdb_rob_idx, cdb_pd, cdb_data, cyc, e.rob, e.pd, e.data, e.cyc);
                end
            end
        end else begin
            checks++;
            if ({cdb_rob_idx, cdb_pd, cdb_data} !== '0) begin
                errors++;
                $display("FAIL cdb_idle_zero: got rob=%0d pd=%0d data=%h, required all zero (cycle %0d)",
                         cdb_rob_idx, cdb_pd, cdb_data, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        flush = 1'b0;
        do_reset();

        // Single result on port 2; nothing may appear in the push cycle.
        t = cyc;
        fu_valid[2]   = 1'b1;
        fu_rob_idx[2] = 5'd3;
        fu_pd[2]      = 6'd9;
        fu_data[2]    = 32'hDEADBEEF;
        sb.push_back('{5'd3, 6'd9, 32'hDEADBEEF, t + LAT});
        @(negedge clk);
        check("no_bypass", cdb_valid, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("single_then_idle", cdb_valid, 0);
        wait_drain("single_drain");

        // Pointer sits on port 2: port 3 must beat port 0.
        u = cyc;
        drive_port(0, 1'b1, 1, 0);
        drive_port(3, 1'b1, 1, 0);
        push_exp(1, 3, 0, u + LAT);
        push_exp(1, 0, 0, u + LAT + 1);
        @(posedge clk);
        #1;
        idle_inputs();
        wait_drain("rr_after_port2");

        // Pointer held on port 0 through idle cycles: port 1 beats port 0.
        u = cyc;
        drive_port(0, 1'b1, 2, 0);
        drive_port(1, 1'b1, 2, 0);
        push_exp(2, 1, 0, u + LAT);
        push_exp(2, 0, 0, u + LAT + 1);
        @(posedge clk);
        #1;
        idle_inputs();
        wait_drain("rr_hold_idle");

        // Fairness: all ports stream 4 results each from reset.
        do_reset();
        t = cyc;
        for (int k = 0; k < 16; k++) push_exp(3, k % 4, k / 4, t + k + LAT);
        cfg_n     = '{4, 4, 4, 4};
        cfg_start = '{0, 0, 0, 0};
        run_stream(3, 20);
        wait_drain("fairness_drain");

        // Backpressure: port 0 offers 3 results one cycle after ports 1-3 start.
        do_reset();
        t = cyc;
        for (int k = 0; k < 12; k++) push_exp(4, (k + 1) % 4, k / 4, t + k + LAT);
        cfg_n     = '{3, 3, 3, 3};
        cfg_start = '{1, 0, 0, 0};
        fork
            run_stream(4, 16);
            begin
                repeat (3) @(negedge clk);
                check("bp_ready0_one_entry", fu_ready[0], 1);
                @(negedge clk);
                check("bp_ready0_full", fu_ready[0], 0);
                @(negedge clk);
                check("bp_ready0_full_during_pop", fu_ready[0], 0);
                @(negedge clk);
                check("bp_ready0_reopened", fu_ready[0], 1);
            end
        join
        wait_drain("backpressure_drain");

        // Flush with concurrent pushes; the pointer must stay on port 2.
        do_reset();
        t = cyc;
        for (int k = 0; k < 4 - LAT; k++) push_exp(5, k, 0, t + k + LAT);
        cfg_n     = '{8, 8, 8, 8};
        cfg_start = '{0, 0, 0, 0};
        run_stream(5, 4);
        flush = 1'b1;
        for (int p = 0; p < NUM_FU; p++) drive_port(p, 1'b1, 6, 0);
        @(negedge clk);
        check("flush_cycle_valid", cdb_valid, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("post_flush_valid", cdb_valid, 0);
        check("post_flush_ready", fu_ready, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        check("flush_sb_drained", sb.size(), 0);
        u = cyc;
        drive_port(0, 1'b1, 7, 0);
        drive_port(3, 1'b1, 7, 0);
        push_exp(7, 3, 0, u + LAT);
        push_exp(7, 0, 0, u + LAT + 1);
        @(posedge clk);
        #1;
        idle_inputs();
        wait_drain("flush_ptr_hold");

        // Asynchronous reset between edges while results are buffered.
        do_reset();
        t = cyc;
        for (int k = 0; k < 4 - LAT; k++) push_exp(8, k, 0, t + k + LAT);
        cfg_n     = '{8, 8, 8, 8};
        cfg_start = '{0, 0, 0, 0};
        run_stream(8, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", cdb_valid, 0);
        check("async_rst_fields", {cdb_rob_idx, cdb_pd, cdb_data}, 0);
        check("async_rst_ready", fu_ready, 4'hF);
        check("async_sb_drained", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        u = cyc;
        for (int p = 0; p < NUM_FU; p++) begin
            drive_port(p, 1'b1, 9, 0);
            push_exp(9, p, 0, u + LAT + p);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        wait_drain("async_first_grant");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
